// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO pin bank: output-register opcodes and default sizing.
package gpio_pkg;

  typedef enum logic [1:0] {
    GPIO_OP_WRITE = 2'b00,
    GPIO_OP_SET   = 2'b01,
    GPIO_OP_CLR   = 2'b10,
    GPIO_OP_TGL   = 2'b11
  } gpio_op_e;

  localparam int GPIO_SYNC_STAGES = 2;
  localparam int GPIO_DB_CNT_W    = 8;

endpackage

// File: rtl/gpio_pin_filter.sv
// One input pin: synchroniser chain, debounce qualifier and registered edge pulses.
module gpio_pin_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 8
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                gpio_in_raw,
  input  logic                db_en,
  input  logic [DB_CNT_W-1:0] db_threshold,
  output logic                sync_gpio_in,
  output logic                db_gpio_in,
  output logic                rise_pulse,
  output logic                fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   db_q;
  logic                   db_d;
  logic [DB_CNT_W-1:0]    cnt_q;
  logic [DB_CNT_W-1:0]    cnt_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in_raw};
    end
  end

  assign sync_gpio_in = sync_q[SYNC_STAGES-1];

  // cnt_q holds the number of earlier consecutive differing cycles, so the
  // compare fires on the (threshold+1)-th one and the counter cannot wrap.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (!db_en) begin
      db_d = sync_gpio_in;
    end else if (sync_gpio_in != db_q) begin
      if (cnt_q >= db_threshold) begin
        db_d = sync_gpio_in;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      db_q       <= 1'b0;
      cnt_q      <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      db_q       <= db_d;
      cnt_q      <= cnt_d;
      rise_pulse <= db_d & ~db_q;
      fall_pulse <= ~db_d & db_q;
    end
  end

  assign db_gpio_in = db_q;

endmodule

// File: rtl/gpio_pin_bank.sv
// GPIO pin bank: atomic output register with push-pull/open-drain pad drive,
// plus per-pin synchronised, debounced, edge-detected inputs.
module gpio_pin_bank
  import gpio_pkg::*;
#(
  parameter int N_PINS      = 32,
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int DB_CNT_W    = GPIO_DB_CNT_W
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [N_PINS-1:0]   gpio_dir,
  input  logic [N_PINS-1:0]   gpio_od,
  input  logic                out_wr_en,
  input  logic [1:0]          out_wr_op,
  input  logic [N_PINS-1:0]   out_wr_data,
  input  logic [N_PINS-1:0]   gpio_in_raw,
  input  logic [N_PINS-1:0]   db_en,
  input  logic [DB_CNT_W-1:0] db_threshold,
  output logic [N_PINS-1:0]   gpio_out,
  output logic [N_PINS-1:0]   gpio_oe,
  output logic [N_PINS-1:0]   sync_gpio_in,
  output logic [N_PINS-1:0]   db_gpio_in,
  output logic [N_PINS-1:0]   rise_pulse,
  output logic [N_PINS-1:0]   fall_pulse
);

  logic [N_PINS-1:0] out_q;
  logic [N_PINS-1:0] out_d;

  always_comb begin
    out_d = out_q;
    if (out_wr_en) begin
      case (gpio_op_e'(out_wr_op))
        GPIO_OP_WRITE: out_d = out_wr_data;
        GPIO_OP_SET:   out_d = out_q | out_wr_data;
        GPIO_OP_CLR:   out_d = out_q & ~out_wr_data;
        GPIO_OP_TGL:   out_d = out_q ^ out_wr_data;
        default:       out_d = out_q;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  // Open-drain pins only ever drive low; a 1 in out_q releases the pad.
  assign gpio_out = out_q & ~(gpio_dir & gpio_od);
  assign gpio_oe  = gpio_dir & ~(gpio_od & out_q);

  for (genvar i = 0; i < N_PINS; i++) begin : g_pin
    gpio_pin_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CNT_W    (DB_CNT_W)
    ) u_filter (
      .PCLK         (PCLK),
      .PRESETn      (PRESETn),
      .gpio_in_raw  (gpio_in_raw[i]),
      .db_en        (db_en[i]),
      .db_threshold (db_threshold),
      .sync_gpio_in (sync_gpio_in[i]),
      .db_gpio_in   (db_gpio_in[i]),
      .rise_pulse   (rise_pulse[i]),
      .fall_pulse   (fall_pulse[i])
    );
  end

endmodule

// File: tb/tb_gpio_pin_bank.sv
// Self-checking bench for gpio_pin_bank: directed scenarios plus randomized
// traffic, all compared against a cycle-level behavioural model.
module tb_gpio_pin_bank;

  localparam int N = 32;
  localparam int S = 2;
  localparam int W = 8;

  logic          PCLK;
  logic          PRESETn;
  logic [N-1:0]  gpio_dir, gpio_od, out_wr_data, gpio_in_raw, db_en;
  logic          out_wr_en;
  logic [1:0]    out_wr_op;
  logic [W-1:0]  db_threshold;
  logic [N-1:0]  gpio_out, gpio_oe, sync_gpio_in, db_gpio_in, rise_pulse, fall_pulse;

  int checks = 0;
  int errors = 0;

  gpio_pin_bank #(.N_PINS(N), .SYNC_STAGES(S), .DB_CNT_W(W)) dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .gpio_dir     (gpio_dir),
    .gpio_od      (gpio_od),
    .out_wr_en    (out_wr_en),
    .out_wr_op    (out_wr_op),
    .out_wr_data  (out_wr_data),
    .gpio_in_raw  (gpio_in_raw),
    .db_en        (db_en),
    .db_threshold (db_threshold),
    .gpio_out     (gpio_out),
    .gpio_oe      (gpio_oe),
    .sync_gpio_in (sync_gpio_in),
    .db_gpio_in   (db_gpio_in),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Reference model: raw history queue for the synchroniser, run lengths of
  // differing cycles for the debouncer.
  logic [N-1:0] m_out_q, m_db, m_rise, m_fall, m_sync;
  logic [N-1:0] m_hist[$];
  int           m_run[N];

  task automatic model_reset();
    m_out_q = '0; m_db = '0; m_rise = '0; m_fall = '0; m_sync = '0;
    m_hist.delete();
    for (int k = 0; k < S; k++) m_hist.push_front('0);
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      model_reset();
    end else begin
      logic [N-1:0] nd;
      if (out_wr_en) begin
        case (out_wr_op)
          2'd0: m_out_q = out_wr_data;
          2'd1: m_out_q = m_out_q | out_wr_data;
          2'd2: m_out_q = m_out_q & ~out_wr_data;
          default: m_out_q = m_out_q ^ out_wr_data;
        endcase
      end
      nd = m_db;
      for (int i = 0; i < N; i++) begin
        if (m_sync[i] == m_db[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
          if (!db_en[i] || m_run[i] >= int'(db_threshold) + 1) begin
            nd[i] = m_sync[i];
            m_run[i] = 0;
          end
        end
      end
      m_rise = nd & ~m_db;
      m_fall = m_db & ~nd;
      m_db   = nd;
      m_hist.push_front(gpio_in_raw);
      void'(m_hist.pop_back());
      m_sync = m_hist[S-1];
    end
  end

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] e_out, e_oe;
    for (int i = 0; i < N; i++) begin
      if (gpio_dir[i] && gpio_od[i]) begin
        e_out[i] = 1'b0;
        e_oe[i]  = ~m_out_q[i];
      end else begin
        e_out[i] = m_out_q[i];
        e_oe[i]  = gpio_dir[i];
      end
    end
    chk("gpio_out", gpio_out, e_out);
    chk("gpio_oe", gpio_oe, e_oe);
    chk("sync", sync_gpio_in, m_sync);
    chk("db", db_gpio_in, m_db);
    chk("rise", rise_pulse, m_rise);
    chk("fall", fall_pulse, m_fall);
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic out_op(input logic [1:0] op, input logic [N-1:0] data);
    out_wr_en = 1'b1; out_wr_op = op; out_wr_data = data;
    tick();
    out_wr_en = 1'b0;
  endtask

  initial begin
    model_reset();
    PRESETn = 1'b0;
    gpio_dir = '0; gpio_od = '0; out_wr_en = 1'b0; out_wr_op = '0; out_wr_data = '0;
    gpio_in_raw = '0; db_en = '0; db_threshold = '0;
    #12 PRESETn = 1'b1;
    tick();
    chk("reset_out", gpio_out, '0);
    chk("reset_db", db_gpio_in, '0);

    // Output register ops, all push-pull outputs
    gpio_dir = '1;
    out_op(2'd0, 32'hF0F0_F0F0); chk("op_write", gpio_out, 32'hF0F0_F0F0);
    out_op(2'd1, 32'h0000_000F); chk("op_set", gpio_out, 32'hF0F0_F0FF);
    out_op(2'd2, 32'h0000_00F0); chk("op_clr", gpio_out, 32'hF0F0_F00F);
    out_op(2'd3, 32'hFFFF_0000); chk("op_tgl", gpio_out, 32'h0F0F_F00F);
    ticks(2);                    chk("op_hold", gpio_out, 32'h0F0F_F00F);

    // Open-drain on pin 3
    gpio_dir = 32'h8; gpio_od = 32'h8;
    out_op(2'd0, '0);
    chk("od_oe_low", gpio_oe, 32'h8);
    chk("od_out_low", gpio_out, '0);
    out_op(2'd1, 32'h8);
    chk("od_release", gpio_oe, '0);
    chk("od_out_rel", gpio_out, '0);
    gpio_dir = '0; gpio_od = '0;

    // Bypass latency on pin 0
    gpio_in_raw[0] = 1'b1;
    tick(); chk("byp_sync_e1", sync_gpio_in, '0);
    tick(); chk("byp_sync_e2", sync_gpio_in, 32'h1); chk("byp_db_e2", db_gpio_in, '0);
    tick(); chk("byp_db_e3", db_gpio_in, 32'h1); chk("byp_rise_e3", rise_pulse, 32'h1);
    tick(); chk("byp_rise_e4", rise_pulse, '0);

    // Glitch reject on pin 5, threshold 3
    db_threshold = 8'd3; db_en = 32'h20;
    gpio_in_raw[5] = 1'b1; ticks(3); gpio_in_raw[5] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("glitch_db", db_gpio_in & 32'h20, '0);
      chk("glitch_rise", rise_pulse, '0);
    end
    gpio_in_raw[5] = 1'b1;
    ticks(S);     chk("qual_sync", sync_gpio_in & 32'h20, 32'h20);
    ticks(3);     chk("qual_db_early", db_gpio_in & 32'h20, '0);
    tick();       chk("qual_db", db_gpio_in & 32'h20, 32'h20); chk("qual_rise", rise_pulse, 32'h20);
    tick();       chk("qual_rise_end", rise_pulse, '0);
    gpio_in_raw[5] = 1'b0;
    ticks(S + 3); chk("fall_early", fall_pulse, '0);
    tick();       chk("fall_pulse", fall_pulse, 32'h20); chk("fall_db", db_gpio_in & 32'h20, '0);
    tick();       chk("fall_end", fall_pulse, '0);

    // Reset during qualification on pin 7, threshold 10
    db_threshold = 8'd10; db_en = '1;
    gpio_in_raw[7] = 1'b1;
    ticks(S + 5);
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_db", db_gpio_in, '0);
    chk("rst_sync", sync_gpio_in, '0);
    chk("rst_oe", gpio_oe, '0);
    check_all();
    #2 PRESETn = 1'b1;
    for (int k = 1; k <= S + 11; k++) begin
      tick();
      chk("requal_db7", db_gpio_in & 32'h80, (k == S + 11) ? 32'h80 : 32'h0);
    end

    // Threshold lowered mid-count on pin 9
    gpio_in_raw[9] = 1'b1;
    ticks(S + 6);
    chk("thr_db_wait", db_gpio_in & 32'h200, '0);
    db_threshold = 8'd2;
    tick(); chk("thr_db", db_gpio_in & 32'h200, 32'h200); chk("thr_rise", rise_pulse, 32'h200);
    tick(); chk("thr_rise_end", rise_pulse, '0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      out_wr_en   = ($urandom_range(0, 2) == 0);
      out_wr_op   = 2'($urandom_range(0, 3));
      out_wr_data = $urandom;
      gpio_in_raw = gpio_in_raw ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) begin
        gpio_dir = $urandom; gpio_od = $urandom;
      end
      if ($urandom_range(0, 99) == 0) db_en = $urandom;
      if ($urandom_range(0, 99) == 0) db_threshold = W'($urandom_range(0, 5));
      if ($urandom_range(0, 999) == 0) begin
        #2 PRESETn = 1'b0;
        #1 check_all();
        #2 PRESETn = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_pin_bank.md
Name: gpio_pin_bank

Overview:
Parametrised GPIO pin bank. It drives pads from an output register that supports atomic write, set, clear and toggle operations, with per-pin push-pull or open-drain mode. Inputs pass through a configurable-depth synchroniser, then an optional per-pin debounce filter, then rise/fall edge detection. The bank sits between the APB GPIO register file and the pads; the edge pulses feed the GPIO interrupt controller.

Parameters:
N_PINS, 32, number of pins (1..32)
SYNC_STAGES, 2, synchroniser depth (legal range 2..4)
DB_CNT_W, 8, debounce counter width

Ports:
PCLK  in  1  clock
PRESETn  in  1  async active-low reset
gpio_dir  in  N_PINS  1=output, 0=input
gpio_od  in  N_PINS  1=open-drain, 0=push-pull (only meaningful when dir=1)
out_wr_en  in  1  one-cycle output-register update strobe
out_wr_op  in  2  00=write, 01=set, 10=clear, 11=toggle
out_wr_data  in  N_PINS  data or bit mask for out_wr_op
gpio_in_raw  in  N_PINS  asynchronous pad inputs
db_en  in  N_PINS  per-pin debounce enable
db_threshold  in  DB_CNT_W  debounce threshold in cycles (shared by all pins)
gpio_out  out  N_PINS  pad drive value
gpio_oe  out  N_PINS  pad output enable
sync_gpio_in  out  N_PINS  synchronised input
db_gpio_in  out  N_PINS  filtered (debounced) input
rise_pulse  out  N_PINS  one-cycle pulse on a 0->1 change of db_gpio_in
fall_pulse  out  N_PINS  one-cycle pulse on a 1->0 change of db_gpio_in

Behaviour:
- Reset: PRESETn is asynchronous, active-low; clock is PCLK. On reset, out_q, all sync flops, db_q, counters, rise_pulse and fall_pulse are cleared to 0. Therefore gpio_out=0, gpio_oe=0, and no edge pulses occur when reset is released.
- Output register out_q: updates on the PCLK edge where out_wr_en=1.
  - write: out_q=data
  - set: out_q|=data
  - clear: out_q&=~data
  - toggle: out_q^=data
  - out_wr_en=0 holds out_q.
- Pad drive is combinational from out_q, gpio_dir and gpio_od:
  - push-pull: gpio_out=out_q, gpio_oe=dir.
  - open-drain: gpio_out=0, gpio_oe=dir&~out_q (drives low only; out_q=1 releases the pad).
  - dir=0: gpio_oe=0 regardless of gpio_od.
- Synchroniser: SYNC_STAGES-deep flop chain per pin. sync_gpio_in equals gpio_in_raw delayed by SYNC_STAGES PCLK edges.
- Debounce, per pin (stable value db_q, counter cnt):
  - db_en=0: db_q<=sync each cycle and cnt<=0. Latency is 1 cycle after sync.
  - db_en=1 and sync==db_q: cnt<=0.
  - db_en=1 and sync!=db_q and cnt>=db_threshold: db_q<=sync, cnt<=0.
  - Otherwise: cnt<=cnt+1. The counter never wraps, because the >= compare fires first.
  - A change is accepted after db_threshold+1 consecutive differing cycles. Any shorter excursion resets cnt and is rejected.
  - db_threshold=0 behaves the same as bypass.
  - If db_threshold is lowered below a running cnt, the change is accepted on the next differing cycle.
  - If db_en toggles mid-count, the bypass rule applies immediately and cnt is cleared.
- db_gpio_in=db_q.
- Edge pulses are registered: rise_pulse<=next_db_q&~db_q and fall_pulse<=~next_db_q&db_q. Each pulse is high exactly in the first cycle db_gpio_in shows the new value, for 1 cycle.
- Total raw-to-db latency with debounce enabled: SYNC_STAGES+db_threshold+1 edges.
- Reset asserted mid-count: all state clears immediately. After release, each pin re-qualifies from db_q=0.
- Output path and input path are independent. Driving a pin as output does not gate its input path, so readback of driven pads works.

Decomposition:
- Shared package gpio_pkg:
  - out_wr_op encodings (GPIO_OP_WRITE/SET/CLR/TGL)
  - default SYNC_STAGES and DB_CNT_W constants
- Sub-module gpio_pin_filter: one pin containing synchroniser, debounce counter and edge-pulse flops. The bank instantiates it N_PINS times via generate.
- Output register and pad-mode logic stay in the top level.

Test Plan:
- Output ops: write 0xF0F0_F0F0, set 0x0000_000F, clear 0x0000_00F0, toggle 0xFFFF_0000 -> out_q = 0xF0F0_F0FF, 0xF0F0_F00F, 0x0F0F_F00F after the successive ops; gpio_out matches with all pins push-pull, dir=all-ones.
- Open-drain: dir[3]=1, od[3]=1, out_q[3]=0 -> gpio_oe[3]=1 and gpio_out[3]=0; then set out_q[3]=1 -> gpio_oe[3]=0.
- Sync and bypass latency: SYNC_STAGES=2, db_en=0, raw[0] 0->1 -> sync_gpio_in[0] high at edge 2, db_gpio_in[0] and rise_pulse[0] at edge 3; rise_pulse is 1 cycle wide.
- Glitch reject: db_threshold=3, db_en[5]=1; raw[5] high for 3 cycles -> db_gpio_in[5] stays 0 with no pulses; raw[5] high for 4+ cycles -> db_gpio_in[5] rises 4 cycles after sync rises, with a single rise_pulse[5]; later falling input produces a single fall_pulse[5].
- Reset mid-count: db_threshold=10, assert PRESETn low 5 cycles into qualification -> all outputs 0 immediately; after release, raw held high -> db_gpio_in rises at SYNC_STAGES+11 edges.
- Threshold lowered: cnt=6 under db_threshold=10, change db_threshold to 2 -> accept on the next differing cycle; only one rise_pulse.
